// File: rtl/bist_spi_pkg.sv
// Shared types and constants for the SPI loopback self-test engine.
package bist_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Feedback taps b7, b5, b4, b3 of the 8-bit Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;
  localparam int         ERR_W        = 8;

  // One LFSR step: shift left, new LSB is the XOR of the tapped bits.
  function automatic logic [7:0] lfsr_step(input logic [7:0] value);
    return {value[6:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Fibonacci LFSR pattern source with synchronous seed load and step.
module bist_lfsr
  import bist_spi_pkg::*;
#(
  parameter logic [7:0] RESET_VALUE = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_r;

  // Pattern register: load wins over advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= RESET_VALUE;
    end else if (load) begin
      value_r <= seed;
    end else if (advance) begin
      value_r <= lfsr_step(value_r);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/bist_spi_test_engine.sv
// SPI mode-0 loopback self-test: sends LFSR words, compares the echo,
// counts mismatching frames and reports done/pass.
module bist_spi_test_engine
  import bist_spi_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         NUM_PATTERNS = 16,
  parameter int         CLK_DIV      = 2,
  parameter logic [7:0] LFSR_SEED    = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_test,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             cs_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int               BIT_W      = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [7:0]       FRAME_LAST = 8'(NUM_PATTERNS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  state_t            state_r;
  state_t            next_state_s;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [7:0]        frame_cnt_r;
  logic [DATA_W-1:0] tx_r;
  logic [DATA_W-1:0] rx_r;
  logic [7:0]        pattern_s;
  logic [7:0]        pattern_next_s;
  logic              start_s;
  logic              div_tick_s;
  logic              rise_s;
  logic              fall_s;
  logic              last_fall_s;
  logic              mismatch_s;
  logic              sclk_s;
  logic              mosi_s;
  logic              cs_n_s;
  logic              busy_s;
  logic              done_s;

  assign start_s = (state_r == ST_IDLE) && start_test;

  // The pattern under test stays stable from LOAD through CHECK.
  bist_lfsr #(
    .RESET_VALUE (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_s),
    .advance (state_r == ST_CHECK),
    .seed    (LFSR_SEED),
    .value   (pattern_s)
  );

  // Word that will be in the LFSR once the next LOAD is entered.
  always_comb begin
    if (start_s) begin
      pattern_next_s = LFSR_SEED;
    end else begin
      pattern_next_s = lfsr_step(pattern_s);
    end
  end

  // Divider tick and sclk edge strobes while shifting.
  always_comb begin
    div_tick_s  = (div_cnt_r == DIV_LAST);
    rise_s      = (state_r == ST_SHIFT) && div_tick_s && !sclk;
    fall_s      = (state_r == ST_SHIFT) && div_tick_s && sclk;
    last_fall_s = fall_s && (bit_cnt_r == BIT_LAST);
    mismatch_s  = (rx_r != pattern_s);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = start_test ? ST_LOAD : ST_IDLE;
      ST_LOAD:   next_state_s = ST_SHIFT;
      ST_SHIFT:  next_state_s = last_fall_s ? ST_CHECK : ST_SHIFT;
      ST_CHECK:  next_state_s = (frame_cnt_r == FRAME_LAST) ? ST_FINISH : ST_LOAD;
      ST_FINISH: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs, computed for the upcoming state so the registers line up with it.
  always_comb begin
    cs_n_s = !((next_state_s == ST_LOAD) || (next_state_s == ST_SHIFT));
    busy_s = (next_state_s != ST_IDLE);
    done_s = (next_state_s == ST_FINISH);
    if (next_state_s == ST_SHIFT) begin
      if ((state_r == ST_SHIFT) && div_tick_s) begin
        sclk_s = !sclk;
      end else begin
        sclk_s = sclk;
      end
    end else begin
      sclk_s = 1'b0;
    end
    if (next_state_s == ST_LOAD) begin
      mosi_s = pattern_next_s[7];
    end else if (fall_s) begin
      mosi_s = tx_r[DATA_W-2];
    end else begin
      mosi_s = mosi;
    end
  end

  // Registered SPI and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk <= 1'b0;
      mosi <= 1'b0;
      cs_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      sclk <= sclk_s;
      mosi <= mosi_s;
      cs_n <= cs_n_s;
      busy <= busy_s;
      done <= done_s;
    end
  end

  // Shift datapath, frame bookkeeping and result accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r   <= {DIV_W{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      frame_cnt_r <= 8'd0;
      tx_r        <= {DATA_W{1'b0}};
      rx_r        <= {DATA_W{1'b0}};
      err_count   <= {ERR_W{1'b0}};
      pass        <= 1'b0;
    end else begin
      if (state_r == ST_SHIFT) begin
        div_cnt_r <= div_tick_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
      end else begin
        div_cnt_r <= {DIV_W{1'b0}};
      end
      if (state_r == ST_LOAD) begin
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (fall_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (next_state_s == ST_LOAD) begin
        tx_r <= pattern_next_s;
      end else if (fall_s) begin
        tx_r <= {tx_r[DATA_W-2:0], 1'b0};
      end
      if (rise_s) begin
        rx_r <= {rx_r[DATA_W-2:0], miso};
      end
      if (start_s) begin
        frame_cnt_r <= 8'd0;
        err_count   <= {ERR_W{1'b0}};
        pass        <= 1'b0;
      end else if (state_r == ST_CHECK) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
        if (mismatch_s && (err_count != ERR_MAX)) begin
          err_count <= err_count + ERR_W'(1);
        end
      end else if (state_r == ST_FINISH) begin
        pass <= (err_count == {ERR_W{1'b0}});
      end
    end
  end

endmodule

// File: tb/tb_bist_spi_test_engine.sv
// Directed self-checking bench for the SPI loopback self-test engine.
module tb_bist_spi_test_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_test;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;

  int tests_run    = 0;
  int tests_failed = 0;

  bit loop_en    = 1'b1;
  bit flip_en    = 1'b0;
  int base_frame = 0;

  // Monitor state
  int         frame_idx  = 0;
  int         rise_idx   = 0;
  int         low_len    = 0;
  int         high_len   = 0;
  int         run_frames = 0;
  int         run_cnt    = 0;
  int         done_cnt   = 0;
  int         cyc        = 0;
  int         last_rise  = 0;
  int         bad_rise_cs = 0;
  int         bad_period  = 0;
  int         bad_low     = 0;
  int         bad_rises   = 0;
  int         bad_gap     = 0;
  logic [7:0] word       = 8'h00;
  logic [7:0] frame_words [0:255];
  logic [7:0] err_start   [0:7];
  logic       prev_sclk  = 1'b0;
  logic       prev_cs_n  = 1'b1;
  logic       prev_busy  = 1'b0;

  bist_spi_test_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start_test (start_test),
    .miso       (miso),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Loopback, optionally corrupting word bit 2 (6th bit on the wire) of frame 3.
  assign miso = loop_en ? (mosi ^ (flip_en && ((frame_idx - base_frame) == 3) && (rise_idx == 5)))
                        : 1'b0;

  function automatic logic [7:0] model_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Bus monitor sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    cyc++;
    if (busy && !prev_busy) begin
      run_frames = 0;
      if (run_cnt < 8) err_start[run_cnt] = err_count;
      run_cnt++;
    end
    if (!cs_n && prev_cs_n) begin
      if (run_frames > 0 && high_len != 1) bad_gap++;
      low_len  = 0;
      rise_idx = 0;
      word     = 8'h00;
    end
    if (cs_n && !prev_cs_n) begin
      if (low_len != 33) bad_low++;
      if (rise_idx != 8) bad_rises++;
      if (frame_idx < 256) frame_words[frame_idx] = word;
      frame_idx++;
      run_frames++;
      high_len = 0;
    end
    if (!cs_n) low_len++;
    else       high_len++;
    if (sclk && !prev_sclk) begin
      if (cs_n) bad_rise_cs++;
      if (rise_idx > 0 && (cyc - last_rise) != 4) bad_period++;
      last_rise = cyc;
      rise_idx++;
      word = {word[6:0], mosi};
    end
    if (done) done_cnt++;
    prev_sclk = sclk;
    prev_cs_n = cs_n;
    prev_busy = busy;
  end

  task automatic run_and_wait(input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    start_test = 1'b1;
    @(posedge clk);
    #1;
    start_test = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_latency"}, 32'(n), 32'd544);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic check_frames(input string tag, input int base, input int count);
    logic [7:0] exp_w;
    exp_w = 8'hA5;
    for (int i = 0; i < count; i++) begin
      check_eq($sformatf("%s_frame%0d", tag, i), 32'(frame_words[base + i]), 32'(exp_w));
      exp_w = model_next(exp_w);
    end
  endtask

  initial begin
    int         f_done [0:1];
    int         dones;
    int         runs_before;
    int         dones_before;
    reset      = 1'b1;
    start_test = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_err",  32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Scenario 1: clean loopback
    loop_en    = 1'b1;
    base_frame = frame_idx;
    run_and_wait("s1");
    check_eq("s1_pass", 32'(pass), 32'd1);
    check_eq("s1_err",  32'(err_count), 32'd0);
    check_eq("s1_nframes", 32'(frame_idx - base_frame), 32'd16);
    check_eq("s1_first_word",  32'(frame_words[base_frame]),     32'h0000_00A5);
    check_eq("s1_second_word", 32'(frame_words[base_frame + 1]), 32'h0000_004A);
    check_eq("s1_third_word",  32'(frame_words[base_frame + 2]), 32'h0000_0095);
    check_frames("s1", base_frame, 16);

    // Scenario 2: miso stuck low
    loop_en = 1'b0;
    run_and_wait("s2");
    check_eq("s2_err",  32'(err_count), 32'd16);
    check_eq("s2_pass", 32'(pass), 32'd0);

    // Scenario 3: single corrupted bit in frame 3
    loop_en    = 1'b1;
    flip_en    = 1'b1;
    base_frame = frame_idx;
    run_and_wait("s3");
    flip_en = 1'b0;
    check_eq("s3_err",  32'(err_count), 32'd1);
    check_eq("s3_pass", 32'(pass), 32'd0);

    // Scenario 4: start re-pulsed every 3 cycles, miso low so each run ends at 16
    loop_en     = 1'b0;
    base_frame  = frame_idx;
    runs_before = run_cnt;
    dones       = 0;
    for (int i = 0; i < 1400 && dones < 2; i++) begin
      @(negedge clk);
      start_test = ((i % 3) == 0);
      if (done) begin
        f_done[dones] = frame_idx;
        dones++;
      end
    end
    start_test = 1'b0;
    check_eq("s4_done_count", 32'(dones), 32'd2);
    check_eq("s4_run_count", 32'(run_cnt - runs_before), 32'd2);
    if (dones == 2) begin
      check_eq("s4_run1_frames", 32'(f_done[0] - base_frame), 32'd16);
      check_eq("s4_run2_frames", 32'(f_done[1] - f_done[0]), 32'd16);
      check_eq("s4_run2_first", 32'(frame_words[f_done[0]]), 32'h0000_00A5);
      check_eq("s4_run2_second", 32'(frame_words[f_done[0] + 1]), 32'h0000_004A);
    end
    check_eq("s4_run1_err_cleared", 32'(err_start[runs_before]), 32'd0);
    check_eq("s4_run2_err_cleared", 32'(err_start[runs_before + 1]), 32'd0);
    check_eq("s4_final_err", 32'(err_count), 32'd16);

    // Scenario 6: frame timing accumulated over all clean runs so far
    check_eq("t_rise_cs_low",  32'(bad_rise_cs), 32'd0);
    check_eq("t_sclk_period",  32'(bad_period),  32'd0);
    check_eq("t_cs_low_len",   32'(bad_low),     32'd0);
    check_eq("t_rises_frame",  32'(bad_rises),   32'd0);
    check_eq("t_cs_gap",       32'(bad_gap),     32'd0);

    // Scenario 5: reset mid-run, then reset together with start
    repeat (5) @(posedge clk);
    loop_en = 1'b1;
    @(negedge clk);
    start_test = 1'b1;
    @(posedge clk);
    #1;
    start_test = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("s5_cs_n", 32'(cs_n), 32'd1);
    check_eq("s5_sclk", 32'(sclk), 32'd0);
    check_eq("s5_busy", 32'(busy), 32'd0);
    check_eq("s5_err",  32'(err_count), 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    dones_before = done_cnt;
    repeat (700) @(posedge clk);
    #1;
    check_eq("s5_no_done", 32'(done_cnt - dones_before), 32'd0);
    @(negedge clk);
    reset      = 1'b1;
    start_test = 1'b1;
    @(posedge clk);
    #1;
    check_eq("s5_rst_start_busy", 32'(busy), 32'd0);
    check_eq("s5_rst_start_cs_n", 32'(cs_n), 32'd1);
    @(negedge clk);
    reset      = 1'b0;
    start_test = 1'b0;
    base_frame = frame_idx;
    run_and_wait("s5");
    check_eq("s5_pass", 32'(pass), 32'd1);
    check_eq("s5_err_final", 32'(err_count), 32'd0);
    check_eq("s5_first_word", 32'(frame_words[base_frame]), 32'h0000_00A5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
